dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Write-back, write-allocate L1 data-cache controller between CPU MEM stage, 2-way dcache SRAM and data memory.
//  Splits CPU address into tag/index/word, detects hit/miss from SRAM, stalls CPU on miss.
//  Runs victim write-back and line refill over a 256-bit memory handshake.
//  Merges/extracts 32-bit words into/from 256-bit lines.
// PARAMETERS
//  ADDR_W  32   CPU/memory byte-address width
//  IDX_W   4    set-index bits (16 sets)
//  LINE_W  256  line width (32 B, 8 words)
//  TAG_W   25   SRAM tag width: [24] valid, [23] dirty, [22:0] addr tag
// PORTS
//  clk_i           in   1    clock, rising edge
//  rst_i           in   1    reset, asynchronous, active-low
//  cpu_addr_i      in   32   byte address; tag=[31:9] idx=[8:5] word=[4:2]
//  cpu_data_i      in   32   store data
//  cpu_MemRead_i   in   1    load request
//  cpu_MemWrite_i  in   1    store request (never both with MemRead)
//  cpu_data_o      out  32   load data
//  cpu_stall_o     out  1    1 = hold pipeline; CPU keeps request stable
//  sram_index_o    out  4    SRAM set index (= cpu_addr_i[8:5])
//  sram_tag_o      out  25   tag to SRAM {valid,dirty,tag}
//  sram_data_o     out  256  line to SRAM
//  sram_enable_o   out  1    SRAM access enable
//  sram_write_o    out  1    SRAM write strobe
//  sram_tag_i      in   25   hit way's tag, else LRU victim's tag
//  sram_data_i     in   256  hit way's line, else LRU victim's line
//  sram_hit_i      in   1    tag match on valid way
//  mem_addr_o      out  32   line address, [4:0]=0
//  mem_data_o      out  256  write-back line
//  mem_enable_o    out  1    one-cycle request pulse
//  mem_write_o     out  1    1 = write-back, 0 = fill
//  mem_data_i      in   256  fill line, valid with mem_ack_i
//  mem_ack_i       in   1    one-cycle completion pulse, >=1 cycle after request
// BEHAVIOUR
//  req = MemRead|MemWrite. cpu_stall_o = (req & ~sram_hit_i & state==IDLE) | state!=IDLE (combinational).
//  Reset: state=IDLE; all outputs 0; fill buffer cleared.
//  IDLE read hit: cpu_data_o = sram_data_i[word*32 +: 32], same cycle, no stall.
//  IDLE write hit: sram_enable_o=sram_write_o=1, sram_data_o = sram_data_i with word replaced, sram_tag_o={1,1,tag}; no stall.
//  IDLE miss: -> MISS.
//  MISS: victim dirty (tag_i[24]&tag_i[23]) -> WRITEBACK, else -> READMISS.
//  WRITEBACK: mem_enable_o pulse on entry, mem_write_o=1, mem_addr_o={tag_i[22:0],idx,5'b0}, mem_data_o=sram_data_i held; on ack -> READMISS.
//  READMISS: mem_enable_o pulse on entry, mem_write_o=0, mem_addr_o={addr[31:5],5'b0}; on ack latch mem_data_i -> READMISSOK.
//  READMISSOK: sram_enable_o=sram_write_o=1, sram_data_o=fill, sram_tag_o={1,0,addr tag}; -> IDLE.
//  Next IDLE cycle hits; a store then completes as a write hit (write-allocate).
//  mem_ack_i outside WRITEBACK/READMISS is ignored. cpu_data_o is 0 when not a read hit.
//  Reset mid-transaction abandons it: IDLE, no SRAM write, stall low until next req.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0], miss_cnt_o[31:0].
//    hit_cnt_o +1 per IDLE hit with req; miss_cnt_o +1 per IDLE->MISS. Both wrap at 2^32; reset 0.
//  Undefined: no counters, no extra ports, identical behaviour otherwise.
// STRUCTURE
//  dcache_pkg: state enum {IDLE,MISS,WRITEBACK,READMISS,READMISSOK}; localparams for tag/index/word fields,
//    LINE_W, TAG_W, VALID_BIT=24, DIRTY_BIT=23.
//  Sub-module dcache_word_mux: 3-bit word select; extracts a 32-bit word and inserts one into a 256-bit line (combinational).
// TESTING
//  1. Load 0x0000_0204, SRAM miss, clean victim -> MISS,READMISS; mem read addr 0x200; ack -> fill written tag {1,0,0x1}; next cycle data, stall 0.
//  2. Store 0xDEADBEEF to 0x0000_0208 on hit -> same-cycle SRAM write, word 2 replaced, tag dirty=1, no stall.
//  3. Miss with dirty victim tag 0x7 idx 0 -> write-back to 0x0000_0E00 with victim line; fill after ack; two memory transactions.
//  4. Store miss to 0x0000_0400 -> refill then write hit; stall drops the cycle the store is written.
//  5. rst_i low during READMISS -> state IDLE, mem/sram strobes 0, no SRAM write, stall 0.
//  6. DCACHE_STATS_EN: 3 hits + 1 miss -> hit_cnt_o=3, miss_cnt_o=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and field layout for the L1 data-cache controller.
// Address split: tag=[31:9], index=[8:5], word=[4:2], byte=[1:0].
// SRAM tag word: [24] valid, [23] dirty, [22:0] address tag.
package dcache_pkg;

  localparam int ADDR_W    = 32;
  localparam int IDX_W     = 4;
  localparam int LINE_W    = 256;
  localparam int TAG_W     = 25;
  localparam int WORD_W    = 32;
  localparam int WSEL_W    = 3;
  localparam int ATAG_W    = 23;
  localparam int OFS_W     = 5;

  localparam int WSEL_LSB  = 2;
  localparam int IDX_LSB   = 5;
  localparam int TAG_LSB   = 9;

  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_e;

  // Builds a valid SRAM tag word with the given dirty flag.
  function automatic logic [TAG_W-1:0] make_tag(input logic dirty,
                                                input logic [ATAG_W-1:0] atag);
    return {1'b1, dirty, atag};
  endfunction

endpackage

// File: rtl/dcache_word_mux.sv
// Word extract/insert for a 256-bit cache line.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: line_i (256) source line, word_sel_i (3) word index, wdata_i (32) word to insert,
//        rdata_o (32) selected word of line_i, line_o (256) line_i with the selected word replaced.
module dcache_word_mux
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [LINE_W-1:0] line_o
);

  // Bit offset of the selected word: word_sel * 32.
  logic [7:0] bit_ofs;
  assign bit_ofs = {word_sel_i, 5'b0};

  always_comb begin
    rdata_o = line_i[bit_ofs +: WORD_W];
    line_o  = line_i;
    line_o[bit_ofs +: WORD_W] = wdata_i;
  end

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate L1 dcache controller (2-way SRAM, 256-bit memory handshake).
// Latency: hits complete in the request cycle; misses stall through MISS/[WRITEBACK]/READMISS/READMISSOK.
// Backpressure: cpu_stall_o holds the pipeline on a miss until the refilled line hits in IDLE.
// Ports: clk_i/rst_i (async active-low); cpu_* request/response; sram_* tag/data array access;
//        mem_* line-granular memory request (enable pulse) and ack pulse.
// Optional: define DCACHE_STATS_EN to add hit_cnt_o / miss_cnt_o (32-bit, wrapping).
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  sram_index_o,
  output logic [TAG_W-1:0]  sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [TAG_W-1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  state_e state_q, state_d;

  logic              req;
  logic [ATAG_W-1:0] addr_tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic              victim_dirty;

  // High only in the first cycle after a state change; drives the memory request pulse.
  logic              entry_q;
  logic [LINE_W-1:0] fill_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [LINE_W-1:0] wb_data_q;

  logic [WORD_W-1:0] hit_word;
  logic [LINE_W-1:0] merged_line;

  // Byte-offset bits never select anything in a word-addressed cache.
  logic unused_byte_ofs;
  assign unused_byte_ofs = ^cpu_addr_i[WSEL_LSB-1:0];

  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign addr_tag     = cpu_addr_i[ADDR_W-1:TAG_LSB];
  assign idx          = cpu_addr_i[TAG_LSB-1:IDX_LSB];
  assign wsel         = cpu_addr_i[IDX_LSB-1:WSEL_LSB];
  // An invalid way is never written back, whatever its dirty bit says.
  assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

  dcache_word_mux u_word_mux (
    .line_i     (sram_data_i),
    .word_sel_i (wsel),
    .wdata_i    (cpu_data_i),
    .rdata_o    (hit_word),
    .line_o     (merged_line)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      entry_q   <= 1'b0;
      fill_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      // Victim captured once so the write-back payload cannot drift while waiting for ack.
      if (state_q == MISS && victim_dirty) begin
        wb_addr_q <= {sram_tag_i[ATAG_W-1:0], idx, {OFS_W{1'b0}}};
        wb_data_q <= sram_data_i;
      end
      if (state_q == READMISS && mem_ack_i) begin
        fill_q <= mem_data_i;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_index_o  = idx;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (sram_hit_i) begin
            if (cpu_MemRead_i) begin
              cpu_data_o = hit_word;
            end
            if (cpu_MemWrite_i) begin
              sram_enable_o = 1'b1;
              sram_write_o  = 1'b1;
              sram_data_o   = merged_line;
              sram_tag_o    = make_tag(1'b1, addr_tag);
            end
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        cpu_stall_o = 1'b1;
        state_d     = victim_dirty ? WRITEBACK : READMISS;
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = entry_q;
        mem_write_o  = 1'b1;
        mem_addr_o   = wb_addr_q;
        mem_data_o   = wb_data_q;
        if (mem_ack_i) state_d = READMISS;
      end
      READMISS: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = entry_q;
        mem_addr_o   = {cpu_addr_i[ADDR_W-1:IDX_LSB], {OFS_W{1'b0}}};
        if (mem_ack_i) state_d = READMISSOK;
      end
      READMISSOK: begin
        cpu_stall_o   = 1'b1;
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_data_o   = fill_q;
        sram_tag_o    = make_tag(1'b0, addr_tag);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // While reset is held every output is quiet, even with a request pending.
    if (!rst_i) begin
      cpu_data_o    = '0;
      cpu_stall_o   = 1'b0;
      sram_index_o  = '0;
      sram_tag_o    = '0;
      sram_data_o   = '0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state_q == IDLE && req) begin
      if (sram_hit_i) hit_cnt_o  <= hit_cnt_o + 32'd1;
      else            miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Covers reset, load/store hits, clean and dirty misses, store miss, reset mid-refill, optional stats.
module tb_dcache_controller;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_index_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int mem_txn = 0;
  int txn_base;
  logic [255:0] exp_line;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .sram_index_o   (sram_index_o),
    .sram_tag_o     (sram_tag_o),
    .sram_data_o    (sram_data_o),
    .sram_enable_o  (sram_enable_o),
    .sram_write_o   (sram_write_o),
    .sram_tag_i     (sram_tag_i),
    .sram_data_i    (sram_data_i),
    .sram_hit_i     (sram_hit_i),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Counts memory requests seen at clock edges.
  always @(posedge clk_i) if (mem_enable_o === 1'b1) mem_txn = mem_txn + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  // Line whose word k is base+k.
  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  task automatic idle_inputs();
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    sram_hit_i     = 1'b0;
    mem_ack_i      = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b0;
    cpu_addr_i     = '0;
    cpu_data_i     = '0;
    sram_tag_i     = '0;
    sram_data_i    = '0;
    mem_data_i     = '0;
    idle_inputs();

    // Reset state
    settle();
    check("rst_stall", cpu_stall_o, 0);
    check("rst_mem_en", mem_enable_o, 0);
    check("rst_sram_wr", sram_write_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    tick();
    rst_i = 1'b1;

    // 1: load miss, clean victim
    cpu_addr_i    = 32'h0000_0204;
    cpu_MemRead_i = 1'b1;
    sram_tag_i    = 25'h0;
    sram_data_i   = mk_line(32'h1111_0000);
    settle();
    check("t1_idle_stall", cpu_stall_o, 1);
    check("t1_idle_data", cpu_data_o, 0);
    tick();
    settle();
    check("t1_miss_mem_en", mem_enable_o, 0);
    tick();
    settle();
    check("t1_rm_mem_en", mem_enable_o, 1);
    check("t1_rm_mem_wr", mem_write_o, 0);
    check("t1_rm_addr", mem_addr_o, 32'h0000_0200);
    tick();
    settle();
    check("t1_rm_pulse_end", mem_enable_o, 0);
    mem_ack_i  = 1'b1;
    mem_data_i = mk_line(32'hF000_0000);
    tick();
    mem_ack_i  = 1'b0;
    settle();
    check("t1_ok_sram_wr", sram_write_o, 1);
    check("t1_ok_sram_en", sram_enable_o, 1);
    check("t1_ok_line", sram_data_o, mk_line(32'hF000_0000));
    check("t1_ok_tag", sram_tag_o, 25'h100_0001);
    check("t1_ok_stall", cpu_stall_o, 1);
    tick();
    sram_hit_i  = 1'b1;
    sram_tag_i  = 25'h100_0001;
    sram_data_i = mk_line(32'hF000_0000);
    settle();
    check("t1_hit_stall", cpu_stall_o, 0);
    check("t1_hit_data", cpu_data_o, 32'hF000_0001);
    check("t1_hit_sram_wr", sram_write_o, 0);
    tick();

    // 2: store hit
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b1;
    cpu_addr_i     = 32'h0000_0208;
    cpu_data_i     = 32'hDEAD_BEEF;
    settle();
    exp_line = mk_line(32'hF000_0000);
    exp_line[95:64] = 32'hDEAD_BEEF;
    check("t2_stall", cpu_stall_o, 0);
    check("t2_sram_wr", sram_write_o, 1);
    check("t2_sram_en", sram_enable_o, 1);
    check("t2_line", sram_data_o, exp_line);
    check("t2_tag", sram_tag_o, 25'h180_0001);
    check("t2_idx", sram_index_o, 4'h0);
    check("t2_cpu_data", cpu_data_o, 0);
    tick();

    // Stray ack in IDLE is ignored
    idle_inputs();
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("stray_ack_sram_wr", sram_write_o, 0);
    check("stray_ack_stall", cpu_stall_o, 0);
    tick();

    // 3: load miss with dirty victim tag 7, idx 0
    txn_base      = mem_txn;
    cpu_addr_i    = 32'h0000_000C;
    cpu_MemRead_i = 1'b1;
    sram_hit_i    = 1'b0;
    sram_tag_i    = 25'h180_0007;
    sram_data_i   = mk_line(32'hA000_0000);
    tick();
    tick();
    settle();
    check("t3_wb_en", mem_enable_o, 1);
    check("t3_wb_wr", mem_write_o, 1);
    check("t3_wb_addr", mem_addr_o, 32'h0000_0E00);
    check("t3_wb_data", mem_data_o, mk_line(32'hA000_0000));
    tick();
    settle();
    check("t3_wb_pulse_end", mem_enable_o, 0);
    check("t3_wb_wr_hold", mem_write_o, 1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("t3_rm_en", mem_enable_o, 1);
    check("t3_rm_wr", mem_write_o, 0);
    check("t3_rm_addr", mem_addr_o, 32'h0000_0000);
    tick();
    mem_ack_i  = 1'b1;
    mem_data_i = mk_line(32'hB000_0000);
    tick();
    mem_ack_i  = 1'b0;
    settle();
    check("t3_ok_line", sram_data_o, mk_line(32'hB000_0000));
    check("t3_ok_tag", sram_tag_o, 25'h100_0000);
    tick();
    sram_hit_i  = 1'b1;
    sram_tag_i  = 25'h100_0000;
    sram_data_i = mk_line(32'hB000_0000);
    settle();
    check("t3_hit_data", cpu_data_o, 32'hB000_0003);
    check("t3_hit_stall", cpu_stall_o, 0);
    check("t3_mem_txns", mem_txn - txn_base, 2);
    tick();

    // 4: store miss, invalid victim with dirty bit set (must not write back)
    idle_inputs();
    cpu_addr_i     = 32'h0000_0400;
    cpu_data_i     = 32'h1234_5678;
    cpu_MemWrite_i = 1'b1;
    sram_tag_i     = 25'h080_0005;
    sram_data_i    = mk_line(32'hD000_0000);
    settle();
    check("t4_idle_stall", cpu_stall_o, 1);
    check("t4_idle_sram_wr", sram_write_o, 0);
    tick();
    tick();
    settle();
    check("t4_rm_en", mem_enable_o, 1);
    check("t4_rm_wr", mem_write_o, 0);
    check("t4_rm_addr", mem_addr_o, 32'h0000_0400);
    tick();
    mem_ack_i  = 1'b1;
    mem_data_i = mk_line(32'hC000_0000);
    tick();
    mem_ack_i  = 1'b0;
    settle();
    check("t4_ok_tag", sram_tag_o, 25'h100_0002);
    check("t4_ok_stall", cpu_stall_o, 1);
    tick();
    sram_hit_i  = 1'b1;
    sram_tag_i  = 25'h100_0002;
    sram_data_i = mk_line(32'hC000_0000);
    settle();
    exp_line = mk_line(32'hC000_0000);
    exp_line[31:0] = 32'h1234_5678;
    check("t4_wr_stall", cpu_stall_o, 0);
    check("t4_wr_en", sram_write_o, 1);
    check("t4_wr_line", sram_data_o, exp_line);
    check("t4_wr_tag", sram_tag_o, 25'h180_0002);
    tick();

    // 5: reset during READMISS
    idle_inputs();
    cpu_addr_i    = 32'h0000_0600;
    cpu_MemRead_i = 1'b1;
    sram_tag_i    = 25'h0;
    tick();
    tick();
    settle();
    check("t5_rm_en", mem_enable_o, 1);
    tick();
    rst_i = 1'b0;
    settle();
    check("t5_rst_stall", cpu_stall_o, 0);
    check("t5_rst_mem_en", mem_enable_o, 0);
    check("t5_rst_sram_wr", sram_write_o, 0);
    check("t5_rst_sram_en", sram_enable_o, 0);
    mem_ack_i  = 1'b1;
    mem_data_i = mk_line(32'hEEEE_0000);
    tick();
    mem_ack_i     = 1'b0;
    cpu_MemRead_i = 1'b0;
    rst_i         = 1'b1;
    settle();
    check("t5_post_stall", cpu_stall_o, 0);
    check("t5_post_sram_wr", sram_write_o, 0);
    tick();
    settle();
    check("t5_no_refill_wr", sram_write_o, 0);
    cpu_MemRead_i = 1'b1;
    sram_hit_i    = 1'b1;
    sram_data_i   = mk_line(32'h5000_0000);
    #1;
    check("t5_idle_hit_stall", cpu_stall_o, 0);
    check("t5_idle_hit_data", cpu_data_o, 32'h5000_0000);
    tick();

`ifdef DCACHE_STATS_EN
    // 6: 3 hits + 1 miss after a fresh reset
    idle_inputs();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    settle();
    check("t6_rst_hits", hit_cnt_o, 0);
    check("t6_rst_miss", miss_cnt_o, 0);
    cpu_addr_i    = 32'h0000_0204;
    cpu_MemRead_i = 1'b1;
    sram_hit_i    = 1'b1;
    tick();
    tick();
    tick();
    sram_hit_i = 1'b0;
    sram_tag_i = 25'h0;
    tick();
    settle();
    check("t6_hits", hit_cnt_o, 3);
    check("t6_miss", miss_cnt_o, 1);
    idle_inputs();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
